// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart1 transmitter between NUM_REQ byte producers.
// Latency: req sampled at edge E -> uart_start high after E; ack one cycle after busy is seen low.
// Backpressure: requesters hold req/data until ack; a stalled UART is abandoned after TIMEOUT cycles.
`timescale 1ns/1ps

module uart_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 1023,
   parameter int ID_W    = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        ack,
   output logic                      uart_start,
   output logic [DATA_W-1:0]         uart_data,
   input  logic                      uart_busy,
   output logic [ID_W-1:0]           grant_id,
   output logic                      active,
   output logic                      err_timeout
);

   localparam int              CNT_W    = $clog2(TIMEOUT + 1);
   localparam int              SLOTS    = 2 ** ID_W;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
   localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_START     = 2'd1,
      S_WAIT_DONE = 2'd2,
      S_DONE      = 2'd3
   } state_t;

   state_t              state, state_n;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic [ID_W-1:0]     last_grant, last_grant_n;
   logic [ID_W-1:0]     grant_id_n;
   logic [DATA_W-1:0]   uart_data_n;
   logic                uart_start_n;
   logic [NUM_REQ-1:0]  ack_n;
   logic                err_timeout_n;
   logic                active_n;

   // Requests and bytes padded out to the full ID_W index space so the
   // round-robin pointer can index them directly; unused slots never request.
   logic [SLOTS-1:0]    req_ext;
   logic [DATA_W-1:0]   slot_data [SLOTS];

   assign req_ext = SLOTS'(req);

   for (genvar g = 0; g < SLOTS; g++) begin : g_slot
      if (g < NUM_REQ) begin : g_used
         assign slot_data[g] = req_data[g*DATA_W +: DATA_W];
      end else begin : g_pad
         assign slot_data[g] = '0;
      end
   end

   logic                win_found;
   logic [ID_W-1:0]     win_idx;
   logic [ID_W-1:0]     cand;

   // Round-robin search: walk from last_grant+1 with wrap at NUM_REQ; first pending wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = last_grant;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (cand == LAST_ID) ? '0 : cand + ID_W'(1);
         if (!win_found && req_ext[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Next-state and next-output logic; every output is registered from these values.
   always_comb begin
      state_n       = state;
      cnt_n         = cnt;
      last_grant_n  = last_grant;
      grant_id_n    = grant_id;
      uart_data_n   = uart_data;
      uart_start_n  = uart_start;
      ack_n         = '0;
      err_timeout_n = 1'b0;

      case (state)
         S_IDLE: begin
            if (win_found) begin
               state_n      = S_START;
               grant_id_n   = win_idx;
               uart_data_n  = slot_data[win_idx];
               uart_start_n = 1'b1;
               cnt_n        = '0;
            end
         end

         S_START: begin
            if (uart_busy) begin
               uart_start_n = 1'b0;
               cnt_n        = '0;
               state_n      = S_WAIT_DONE;
            end else if (cnt == CNT_MAX) begin
               // UART never accepted the byte: abandon it, skip this requester once.
               uart_start_n  = 1'b0;
               err_timeout_n = 1'b1;
               last_grant_n  = grant_id;
               state_n       = S_IDLE;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end

         S_WAIT_DONE: begin
            uart_start_n = 1'b0;
            if (!uart_busy) begin
               // ack is raised on entry to DONE so it is high exactly while in DONE.
               ack_n   = ONE_HOT0 << grant_id;
               state_n = S_DONE;
            end else if (cnt == CNT_MAX) begin
               err_timeout_n = 1'b1;
               last_grant_n  = grant_id;
               state_n       = S_IDLE;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end

         S_DONE: begin
            last_grant_n = grant_id;
            state_n      = S_IDLE;
         end

         default: begin
            state_n      = S_IDLE;
            uart_start_n = 1'b0;
         end
      endcase

      active_n = (state_n != S_IDLE);
   end

   // State and registered outputs; reset drops every output immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         last_grant  <= LAST_ID;
         grant_id    <= '0;
         uart_data   <= '0;
         uart_start  <= 1'b0;
         ack         <= '0;
         err_timeout <= 1'b0;
         active      <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         last_grant  <= last_grant_n;
         grant_id    <= grant_id_n;
         uart_data   <= uart_data_n;
         uart_start  <= uart_start_n;
         ack         <= ack_n;
         err_timeout <= err_timeout_n;
         active      <= active_n;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed plus randomized bench for uart_tx_arbiter with a behavioural uart1 busy model.
// Expected grants come from a round-robin pick over the request mask.
// Checks grant order, latched data, ack/timeout pulses and reset behaviour.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 8;
   localparam int TIMEOUT = 1023;
   localparam int ID_W    = 2;

   logic                      clk;
   logic                      reset;
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        ack;
   logic                      uart_start;
   logic [DATA_W-1:0]         uart_data;
   logic                      uart_busy;
   logic [ID_W-1:0]           grant_id;
   logic                      active;
   logic                      err_timeout;

   int vectors     = 0;
   int miscompares = 0;

   int  rise_dly  = 3;
   int  busy_len  = 20;
   bit  uart_dead = 1'b0;
   int  ref_last  = NUM_REQ - 1;
   logic [DATA_W-1:0] dat [NUM_REQ];

   uart_tx_arbiter #(
      .NUM_REQ (NUM_REQ),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT),
      .ID_W    (ID_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .req_data    (req_data),
      .ack         (ack),
      .uart_start  (uart_start),
      .uart_data   (uart_data),
      .uart_busy   (uart_busy),
      .grant_id    (grant_id),
      .active      (active),
      .err_timeout (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // uart1 stand-in: busy rises rise_dly cycles after start is seen, stays busy_len cycles.
   initial begin
      int phase;
      int cnt;
      phase     = 0;
      cnt       = 0;
      uart_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (reset !== 1'b1) begin
            phase     = 0;
            uart_busy = 1'b0;
         end else begin
            case (phase)
               0: if (uart_start === 1'b1 && !uart_dead) begin
                     cnt = rise_dly - 1;
                     if (cnt <= 0) begin
                        uart_busy = 1'b1;
                        cnt       = busy_len;
                        phase     = 2;
                     end else begin
                        phase = 1;
                     end
                  end
               1: begin
                     cnt = cnt - 1;
                     if (cnt <= 0) begin
                        uart_busy = 1'b1;
                        cnt       = busy_len;
                        phase     = 2;
                     end
                  end
               2: begin
                     cnt = cnt - 1;
                     if (cnt <= 0) begin
                        uart_busy = 1'b0;
                        phase     = 0;
                     end
                  end
               default: phase = 0;
            endcase
         end
      end
   end

   // Global time bound so the bench always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: observed no completion, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   // Round-robin rule: first pending requester after the last one served, with wrap.
   function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] mask);
      for (int d = 1; d <= NUM_REQ; d++) begin
         if (mask[(last + d) % NUM_REQ]) return (last + d) % NUM_REQ;
      end
      return -1;
   endfunction

   task automatic drive_data;
      for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = dat[i];
   endtask

   task automatic do_reset;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_ack",        32'(ack),         0);
      chk("rst_uart_start", 32'(uart_start),  0);
      chk("rst_uart_data",  32'(uart_data),   0);
      chk("rst_grant_id",   32'(grant_id),    0);
      chk("rst_active",     32'(active),      0);
      chk("rst_err",        32'(err_timeout), 0);
      repeat (2) @(negedge clk);
      reset    = 1'b1;
      ref_last = NUM_REQ - 1;
      @(negedge clk);
   endtask

   task automatic wait_start(input int exp_id, input logic [DATA_W-1:0] exp_dat);
      int n;
      n = 0;
      while (uart_start !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("start_seen", 32'(uart_start), 1);
      chk("grant_id",   32'(grant_id),   32'(exp_id));
      chk("uart_data",  32'(uart_data),  32'(exp_dat));
      chk("active_busy",32'(active),     1);
   endtask

   task automatic finish(input int exp_id, input logic [DATA_W-1:0] exp_dat,
                         input bit exp_to, output int sc);
      int n;
      n  = 0;
      sc = 1;
      while (n < 2*TIMEOUT + 100) begin
         @(negedge clk);
         n++;
         if (uart_start === 1'b1) begin
            sc++;
            chk("data_hold", 32'(uart_data), 32'(exp_dat));
         end
         if (ack !== '0 || err_timeout !== 1'b0) break;
      end
      chk("ack",        32'(ack),         exp_to ? 0 : (1 << exp_id));
      chk("err_pulse",  32'(err_timeout), 32'(exp_to));
      chk("grant_hold", 32'(grant_id),    32'(exp_id));
      if (exp_to) begin
         chk("active_to", 32'(active), 0);
      end else begin
         chk("active_done", 32'(active), 1);
         @(negedge clk);
         chk("ack_one_cycle", 32'(ack),    0);
         chk("active_idle",   32'(active), 0);
      end
      ref_last = exp_id;
   endtask

   initial begin
      int e;
      int sc;
      reset    = 1'b1;
      req      = '0;
      req_data = '0;
      for (int i = 0; i < NUM_REQ; i++) dat[i] = '0;

      // 1: single requester, busy after 3 cycles for 20 cycles
      do_reset();
      rise_dly = 3; busy_len = 20;
      dat[0] = 8'hA5; drive_data();
      req = 4'b0001;
      wait_start(0, 8'hA5);
      finish(0, 8'hA5, 1'b0, sc);
      chk("t1_start_cycles", 32'(sc), 3);
      req = '0;
      @(negedge clk);
      chk("t1_active_low", 32'(active), 0);

      // 2: two requesters, each held until its own ack
      do_reset();
      rise_dly = 2; busy_len = 5;
      dat[0] = 8'h11; dat[2] = 8'h22; drive_data();
      req = 4'b0101;
      e = rr_pick(ref_last, req);
      wait_start(e, dat[e]);
      finish(e, dat[e], 1'b0, sc);
      req[e] = 1'b0;
      e = rr_pick(ref_last, req);
      wait_start(e, dat[e]);
      finish(e, dat[e], 1'b0, sc);
      req = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t2_no_extra_ack", 32'(ack), 0);
      end

      // 3: all requesting continuously, fresh byte after each ack
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) dat[i] = 8'($urandom);
      drive_data();
      req = 4'b1111;
      for (int t = 0; t < 8; t++) begin
         rise_dly = int'($urandom_range(1, 4));
         busy_len = int'($urandom_range(1, 6));
         e = rr_pick(ref_last, req);
         wait_start(e, dat[e]);
         chk("t3_rr_order", 32'(grant_id), 32'(t % NUM_REQ));
         finish(e, dat[e], 1'b0, sc);
         dat[e] = 8'($urandom);
         drive_data();
      end
      req = '0;

      // 4: dead UART -> timeout, then the timed-out requester is skipped once
      do_reset();
      uart_dead = 1'b1;
      dat[0] = 8'h3C; dat[1] = 8'h96; drive_data();
      req = 4'b0010;
      wait_start(1, 8'h96);
      finish(1, 8'h96, 1'b1, sc);
      chk("t4_start_cycles", 32'(sc), TIMEOUT + 1);
      uart_dead = 1'b0;
      rise_dly  = 2; busy_len = 3;
      req = 4'b0011;
      e = rr_pick(ref_last, req);
      wait_start(e, dat[e]);
      chk("t4_skip_to_0", 32'(grant_id), 0);
      finish(e, dat[e], 1'b0, sc);
      req[e] = 1'b0;
      e = rr_pick(ref_last, req);
      wait_start(e, dat[e]);
      finish(e, dat[e], 1'b0, sc);
      req = '0;

      // 5: reset during WAIT_DONE
      rise_dly = 2; busy_len = 20;
      dat[2] = 8'h5E; drive_data();
      req = 4'b0100;
      e = rr_pick(ref_last, req);
      wait_start(e, dat[e]);
      for (int n = 0; n < 20 && !(uart_busy === 1'b1 && uart_start === 1'b0); n++) @(negedge clk);
      chk("t5_in_wait_done", 32'(uart_start), 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("t5_rst_start",  32'(uart_start), 0);
      chk("t5_rst_ack",    32'(ack),        0);
      chk("t5_rst_active", 32'(active),     0);
      chk("t5_rst_grant",  32'(grant_id),   0);
      req = 4'b1000;
      dat[3] = 8'hE7; drive_data();
      repeat (3) @(negedge clk);
      reset    = 1'b1;
      ref_last = NUM_REQ - 1;
      busy_len = 4;
      e = rr_pick(ref_last, req);
      wait_start(e, dat[e]);
      finish(e, dat[e], 1'b0, sc);
      req = '0;

      // 6: data changed and req dropped after grant; in-flight byte unaffected
      rise_dly = 4; busy_len = 5;
      dat[0] = 8'h5A; drive_data();
      req = 4'b0001;
      e = rr_pick(ref_last, req);
      wait_start(e, 8'h5A);
      dat[0] = 8'hC3; drive_data();
      req = '0;
      finish(e, 8'h5A, 1'b0, sc);

      // 7: randomized masks, bytes and UART timing
      for (int t = 0; t < 24; t++) begin
         req = 4'($urandom_range(1, 15));
         for (int i = 0; i < NUM_REQ; i++) dat[i] = 8'($urandom);
         drive_data();
         rise_dly = int'($urandom_range(1, 5));
         busy_len = int'($urandom_range(1, 8));
         e = rr_pick(ref_last, req);
         wait_start(e, dat[e]);
         finish(e, dat[e], 1'b0, sc);
      end
      req = '0;
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart1 transmitter between NUM_REQ byte producers, e.g. a command sequencer, a status reporter and a debug port.
- Picks one pending requester by round-robin.
- Latches its byte and drives the uart1 start_transmission / data_in pair.
- Tracks uart1 busy through assert and release, then acknowledges the requester.
- Flags a stalled transmitter with a timeout instead of hanging.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width; must match uart1 data_in
TIMEOUT, 1023, clk cycles allowed in START for uart_busy to assert (also bounds WAIT_DONE)
ID_W, 2, width of grant_id; must be >= clog2(NUM_REQ)

Ports:
clk  input  1  system clock; all logic rises on posedge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
req  input  NUM_REQ  per-requester byte-pending level
req_data  input  NUM_REQ*DATA_W  requester i byte at [i*DATA_W +: DATA_W]
ack  output  NUM_REQ  one-cycle pulse: requester's byte fully transmitted
uart_start  output  1  to uart1 start_transmission
uart_data  output  DATA_W  to uart1 data_in
uart_busy  input  1  from uart1 busy, treated as synchronous to clk
grant_id  output  ID_W  index of requester currently owning the UART
active  output  1  high in any state except IDLE
err_timeout  output  1  one-cycle pulse when a timeout aborts or ends a transaction

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ack=0, uart_start=0, uart_data=0, grant_id=0, active=0, err_timeout=0, timeout counter=0, last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
- All outputs are registered.
- FSM states: IDLE, START, WAIT_DONE, DONE.
- IDLE:
  - If req != 0, search from (last_grant+1) mod NUM_REQ upward with wrap; the first set bit wins.
  - On that edge: grant_id=winner, uart_data=winner's req_data slice, uart_start=1, counter=0, go START.
  - Latency: req sampled at edge E → uart_start=1 after E.
- START:
  - Hold uart_start=1 and uart_data stable; counter increments each cycle.
  - uart_busy=1 → uart_start=0, counter=0, go WAIT_DONE.
  - Else if counter==TIMEOUT → uart_start=0, err_timeout pulse, last_grant=grant_id, go IDLE. No ack; the requester's req stays pending and the next arbitration skips it once.
- WAIT_DONE:
  - uart_start=0; counter increments.
  - uart_busy=0 → go DONE.
  - counter==TIMEOUT → err_timeout pulse, last_grant=grant_id, go IDLE, no ack.
- DONE: ack[grant_id]=1 for exactly one cycle, last_grant=grant_id, go IDLE.
- At most one ack bit is ever high. ack and err_timeout are never high in the same cycle.
- Requester handshake:
  - Hold req and data stable until ack.
  - Drop req, or present the next byte, in the cycle after ack.
  - IDLE lasts at least one cycle between transactions, so a requester reacting to ack by the next edge is never double-served.
- Data is latched at grant. Changing req_data or dropping req after grant does not affect the in-flight byte; the transaction still completes and acks.
- Requests arriving outside IDLE wait; no queueing beyond the req level.
- Fairness: with all req high, grants cycle 0,1,2,3,0...; no requester waits more than NUM_REQ-1 transactions.
- uart_busy already high in IDLE: ignored. START still waits for uart_busy=1, which is met immediately.
- Reset mid-transaction: outputs drop immediately. The uart1 byte may be truncated; the arbiter does not retry.
- Counter width is clog2(TIMEOUT+1); it never wraps before the compare.

Test Plan:
1. Reset, req=0001, data0=8'hA5; model busy rises 3 cycles after start, lasts 20 cycles → uart_start high 3 cycles, uart_data=A5, grant_id=0, ack=0001 one cycle after busy falls, active low afterwards.
2. req=0101 (data0=11, data2=22), hold each until its ack → transmit order 11 then 22, grant_id 0 then 2, exactly two ack pulses.
3. req=1111 held continuously, 8 transactions → grant_id sequence 0,1,2,3,0,1,2,3; never two acks in one cycle.
4. uart_busy tied 0, req=0010 → uart_start high for TIMEOUT+1 cycles then low, err_timeout pulse, no ack; then req=0011 → requester 0 granted next.
5. Assert reset low during WAIT_DONE → uart_start, ack, active, grant_id all 0 at once; after release, req=1000 → grant_id=0 priority restored, then requester 3 served.
6. Change req_data and drop req during START → uart_data keeps the original byte; transaction completes with ack.
